nibble_serial_adder16: RTL

Multi-cycle, nibble-serial wide adder that drives the existing `CLA_4bit` block and consumes its `Sum`/`Cout` outputs. It adds two `4*NIBBLES`-bit operands one nibble per clock, least-significant nibble first, and carries `Cout` between nibbles in a register. It sits downstream of operand sources behind a valid/ready handshake and presents a registered result with carry and signed-overflow flags. This lets the team build wide adders from the 4-bit CLA without replicating it.

---
 rtl/nsa_pkg.sv | 16 +
 rtl/nibble_serial_adder16_cla.sv | 27 ++
 rtl/nibble_serial_adder16.sv | 128 ++++++++++++
 3 files changed

// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

    localparam int NIBBLE_W = 4;

    function automatic int cnt_w(input int nibbles);
        return $clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_serial_adder16_cla.sv
// 4-bit carry-lookahead adder; the existing CLA_4bit block reused by the serial adder.
module CLA_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign Sum  = p ^ c[3:0];
    assign Cout = c[4];

endmodule

// File: rtl/nibble_serial_adder16.sv
// Nibble-serial wide adder time-multiplexing one CLA_4bit, LS nibble first.
// Optional subtract mode (port sub) is enabled by defining NSA_SUB_EN.
module nibble_serial_adder16
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]   a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   b,
    input  logic                          cin,
`ifdef NSA_SUB_EN
    input  logic                          sub,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]   sum,
    output logic                          cout,
    output logic                          ovf
);

    localparam int W   = NIBBLE_W * NIBBLES;
    localparam int K_W = cnt_w(NIBBLES);

    nsa_state_t     state_reg;
    logic [K_W-1:0] k_reg;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic           carry_reg;
    logic [W-1:0]   sum_reg;
    logic           cout_reg;
    logic           ovf_reg;
    logic           out_valid_reg;

    logic [W-1:0]          b_in;
    logic                  c_in;
    logic [NIBBLE_W-1:0]   a_nib [NIBBLES];
    logic [NIBBLE_W-1:0]   b_nib [NIBBLES];
    logic [NIBBLE_W-1:0]   cla_sum;
    logic                  cla_cout;
    logic [W-1:0]          sum_next;
    logic                  last;

`ifdef NSA_SUB_EN
    // Subtraction is A + ~B + 1, so the operand carry-in is overridden.
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
            assign b_nib[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
            assign sum_next[gi*NIBBLE_W +: NIBBLE_W] =
                (k_reg == K_W'(gi)) ? cla_sum : sum_reg[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    CLA_4bit u_cla (
        .A    (a_nib[k_reg]),
        .B    (b_nib[k_reg]),
        .Cin  (carry_reg),
        .Sum  (cla_sum),
        .Cout (cla_cout)
    );

    assign last = (k_reg == K_W'(NIBBLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            carry_reg     <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b_in;
                        carry_reg <= c_in;
                        k_reg     <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= cla_cout;
                    k_reg     <= k_reg + K_W'(1);
                    if (last) begin
                        cout_reg      <= cla_cout;
                        // Sign bits of the operands agree but the result sign differs.
                        ovf_reg       <= (a_reg[W-1] == b_reg[W-1]) & (sum_next[W-1] != a_reg[W-1]);
                        out_valid_reg <= 1'b1;
                        k_reg         <= '0;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE) & ~rst;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule
